// File: rtl/logic_fifo_sync.sv
// Single-clock AXI4-Stream FIFO with a registered first-word-fall-through output,
// any capacity >= 2, occupancy count, threshold flags and synchronous flush.
module logic_fifo_sync #(
    parameter int WIDTH        = 1,
    parameter int CAPACITY     = 16,
    parameter int ALMOST_FULL  = CAPACITY - 1,
    parameter int ALMOST_EMPTY = 1,
    parameter int USEDW_WIDTH  = $clog2(CAPACITY + 1)
) (
    input  logic                   aclk,
    input  logic                   sreset,
    input  logic                   flush,
    input  logic                   rx_tvalid,
    input  logic [WIDTH-1:0]       rx_tdata,
    output logic                   rx_tready,
    output logic                   tx_tvalid,
    output logic [WIDTH-1:0]       tx_tdata,
    input  logic                   tx_tready,
    output logic [USEDW_WIDTH-1:0] usedw,
    output logic                   almost_full,
    output logic                   almost_empty
);

    localparam int PW = $clog2(CAPACITY);

    generate
        if (CAPACITY < 2) begin : g_drc_cap
            $error("logic_fifo_sync: CAPACITY must be >= 2");
        end
        if (ALMOST_FULL < 1 || ALMOST_FULL > CAPACITY) begin : g_drc_af
            $error("logic_fifo_sync: ALMOST_FULL out of range");
        end
        if (ALMOST_EMPTY < 0 || ALMOST_EMPTY >= CAPACITY) begin : g_drc_ae
            $error("logic_fifo_sync: ALMOST_EMPTY out of range");
        end
    endgenerate

    logic [WIDTH-1:0]       mem [CAPACITY];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [USEDW_WIDTH-1:0] mem_cnt;
    logic [USEDW_WIDTH-1:0] usedw_next;
    logic                   acc;
    logic                   del;
    logic                   out_free;
    logic                   mem_has;
    logic                   bypass;
    logic                   mem_wr;
    logic                   mem_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CAPACITY - 1)) ? '0 : p + PW'(1);
    endfunction

    assign acc      = rx_tvalid && rx_tready;
    assign del      = tx_tvalid && tx_tready;
    // usedw includes the output register; storage holds the rest
    assign mem_cnt  = usedw - USEDW_WIDTH'(tx_tvalid);
    assign out_free = !tx_tvalid || del;
    assign mem_has  = (mem_cnt != '0);
    // an empty FIFO loads the incoming word straight into the output register
    assign bypass   = acc && out_free && !mem_has;
    assign mem_wr   = acc && !bypass;
    assign mem_rd   = out_free && mem_has;

    always_comb begin
        usedw_next = usedw;
        if (acc && !del) begin
            usedw_next = usedw + USEDW_WIDTH'(1);
        end else if (!acc && del) begin
            usedw_next = usedw - USEDW_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (sreset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            rx_tready    <= 1'b0;
            tx_tvalid    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            rx_tready    <= 1'b1;
            tx_tvalid    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (mem_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (mem_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (out_free) begin
                tx_tvalid <= mem_has || acc;
            end
            usedw        <= usedw_next;
            rx_tready    <= usedw_next < USEDW_WIDTH'(CAPACITY);
            almost_full  <= usedw_next >= USEDW_WIDTH'(ALMOST_FULL);
            almost_empty <= usedw_next <= USEDW_WIDTH'(ALMOST_EMPTY);
        end
    end

    always_ff @(posedge aclk) begin
        if (!sreset && !flush) begin
            if (mem_wr) begin
                mem[wr_ptr] <= rx_tdata;
            end
            if (out_free) begin
                tx_tdata <= mem_has ? mem[rd_ptr] : rx_tdata;
            end
        end
    end

endmodule
